// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_pkg
// Description : Shared FSM encoding and bus-width helper for weight_loader_pp.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_BANK = 3'd1;
    localparam state_t ST_FETCH     = 3'd2;
    localparam state_t ST_CAPTURE   = 3'd3;
    localparam state_t ST_UNPACK    = 3'd4;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_PACK       = 4;
    localparam int BUS_W          = DEF_DATA_WIDTH * DEF_PACK;

    function automatic int bus_width(input int data_width, input int pack);
        return data_width * pack;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo
// Description : Synchronous FIFO with registered read data (valid after rd_en).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int WIDTH   = 64,
    parameter int DEPTH_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam logic [DEPTH_W:0] DEPTH = {1'b1, {DEPTH_W{1'b0}}};

    logic [WIDTH-1:0]   mem [2**DEPTH_W];
    logic [DEPTH_W-1:0] wptr;
    logic [DEPTH_W-1:0] rptr;
    logic [DEPTH_W:0]   count;
    logic               push;
    logic               pop;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + DEPTH_W'(1);
            end
            if (pop) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + DEPTH_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_W+1)'(1);
                2'b01:   count <= count - (DEPTH_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram
// Description : Simple dual-port RAM, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/weight_loader_pp.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_pp
// Description : Ping-pong weight loader: unpacks FIFO words into one bank
//               while the PE array reads the other.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader_pp
    import weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int PACK         = 4,
    parameter int FIFO_DEPTH_W = 2,
    parameter int ADDR_W       = 8,
    parameter int PARA_WIDTH   = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [PARA_WIDTH-1:0]      weight_num,
    input  logic [DATA_WIDTH*PACK-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_release,
    output logic [DATA_WIDTH-1:0]      weight_out,
    output logic                       rd_bank_valid,
    output logic                       wr_bank,
    output logic                       load_busy,
    output logic                       load_done
);

    localparam int BUS_WIDTH  = bus_width(DATA_WIDTH, PACK);
    localparam int LANE_W     = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int NUM_W      = ADDR_W + 1;
    localparam int BANK_WORDS = 2**ADDR_W;

    state_t                state;
    state_t                state_next;
    logic [1:0]            bank_valid;
    logic                  rd_bank;
    logic                  wr_bank_q;
    logic [ADDR_W-1:0]     waddr;
    logic [LANE_W-1:0]     lane;
    logic [BUS_WIDTH-1:0]  word_q;
    logic [NUM_W-1:0]      num_q;

    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [BUS_WIDTH-1:0]  fifo_rd_data;
    logic                  ram_we;
    logic                  start_accept;
    logic                  start_zero;
    logic                  finish_load;
    logic                  release_ok;
    logic                  last_weight;
    logic                  lane_last;
    logic [31:0]           weight_num_ext;
    logic [NUM_W-1:0]      num_clamped;
    logic [DATA_WIDTH-1:0] word_lanes [PACK];

    fifo #(
        .WIDTH   (BUS_WIDTH),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .full    (fifo_full),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr ({wr_bank_q, waddr}),
        .wdata (word_lanes[lane]),
        .raddr ({rd_bank, rd_addr}),
        .rdata (weight_out)
    );

    generate
        for (genvar i = 0; i < PACK; i++) begin : g_lanes
            assign word_lanes[i] = word_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A request larger than one bank is clamped to a full bank.
    assign weight_num_ext = 32'(weight_num);
    assign num_clamped    = (weight_num_ext > BANK_WORDS) ? NUM_W'(BANK_WORDS)
                                                          : NUM_W'(weight_num_ext);
    assign last_weight    = ({1'b0, waddr} == (num_q - NUM_W'(1)));
    assign lane_last      = (32'(lane) == PACK - 1);
    assign release_ok     = rd_release && bank_valid[rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_start && (num_clamped != '0)) begin
                    state_next = ST_WAIT_BANK;
                end
            end
            ST_WAIT_BANK: begin
                if (!bank_valid[wr_bank_q]) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_UNPACK;
            end
            ST_UNPACK: begin
                if (last_weight) begin
                    state_next = ST_IDLE;
                end else if (lane_last) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_rd_en   = (state == ST_FETCH) && !fifo_empty;
        ram_we       = (state == ST_UNPACK);
        finish_load  = (state == ST_UNPACK) && last_weight;
        start_accept = (state == ST_IDLE) && load_start;
        start_zero   = start_accept && (num_clamped == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q     <= '0;
            waddr     <= '0;
            lane      <= '0;
            word_q    <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= start_zero || finish_load;
            if (start_accept) begin
                num_q <= num_clamped;
                waddr <= '0;
            end
            if (state == ST_CAPTURE) begin
                word_q <= fifo_rd_data;
                lane   <= '0;
            end
            if (ram_we) begin
                waddr <= waddr + ADDR_W'(1);
                lane  <= lane + LANE_W'(1);
            end
        end
    end

    // Completion and release always touch different banks, so both may land together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_valid <= 2'b00;
            rd_bank    <= 1'b0;
            wr_bank_q  <= 1'b0;
        end else begin
            if (finish_load) begin
                bank_valid[wr_bank_q] <= 1'b1;
                wr_bank_q             <= ~wr_bank_q;
            end
            if (release_ok) begin
                bank_valid[rd_bank] <= 1'b0;
                rd_bank             <= ~rd_bank;
            end
        end
    end

    assign in_ready      = !fifo_full;
    assign rd_bank_valid = bank_valid[rd_bank];
    assign wr_bank       = wr_bank_q;
    assign load_busy     = (state != ST_IDLE);

endmodule
`default_nettype wire
